// File: rtl/urv_defs.sv
`default_nettype none
// ============================================================================
// Package : urv_defs
// Brief   : shared uRV encodings: NOP word, fetch states, default reset vector
// Revision: 1.0
// ============================================================================
package urv_defs;

  localparam logic [31:0] c_nop          = 32'h0000_0013;
  localparam logic [31:0] c_reset_vector = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/urv_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : urv_fetch_queue
// Brief   : synchronous FIFO with flush; push and pop together on full is legal
// Revision: 1.0
// ============================================================================
module urv_fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [c_aw-1:0] f_next(input logic [c_aw-1:0] p);
    return (p == c_aw'(DEPTH - 1)) ? '0 : p + c_aw'(1);
  endfunction

  assign full_o  = (r_count == c_cw'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/urv_fetch.sv
`default_nettype none
// ============================================================================
// Module  : urv_fetch
// Brief   : uRV instruction fetch; URV_FETCH_ALIGN_CHECK_EN adds f_misaligned_o
// Revision: 1.0
// ============================================================================
module urv_fetch
  import urv_defs::*;
#(
  parameter logic [31:0] RESET_VECTOR    = c_reset_vector,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        f_stall_i,
  input  logic        f_kill_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_bra_target_i,
  output logic        im_rd_o,
  output logic [31:0] im_addr_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
`ifdef URV_FETCH_ALIGN_CHECK_EN
  output logic        f_misaligned_o,
`endif
  output logic        f_valid_o
);

  localparam int c_cw = $clog2(MAX_OUTSTANDING + 1);
`ifdef URV_FETCH_ALIGN_CHECK_EN
  localparam int c_tw = 33;
`else
  localparam int c_tw = 32;
`endif
  localparam int            c_qw  = c_tw + 32;
  localparam logic [c_cw:0] c_max = (c_cw + 1)'(MAX_OUTSTANDING);

  fetch_state_t    r_state;
  logic [31:0]     r_pc;
  logic [c_cw-1:0] r_out;
  logic [c_cw-1:0] r_drop;
  logic [c_cw-1:0] w_drop_next;
  logic [c_cw-1:0] w_q_count;
  logic [c_cw-1:0] w_tag_count;
  logic [c_cw:0]   w_inflight;
  logic            w_q_full, w_q_empty, w_tag_full, w_tag_empty;
  logic [c_tw-1:0] w_tag_din, w_tag_dout;
  logic [c_qw-1:0] w_q_dout;
  logic            w_issue, w_accept, w_q_pop;
  logic [31:0]     w_target;

  assign w_target    = x_bra_target_i & 32'hFFFF_FFFC;
  assign w_inflight  = {1'b0, r_out} + {1'b0, w_q_count};
  assign w_issue     = (r_state != FETCH_BOOT) && (w_inflight < c_max) && !x_bra_i;
  assign w_accept    = im_valid_i && (r_drop == '0) && !x_bra_i;
  assign w_q_pop     = !x_bra_i && !f_kill_i && !f_stall_i && !w_q_empty;
  assign w_drop_next = r_out - c_cw'(im_valid_i);
  assign im_rd_o     = w_issue;
  assign im_addr_o   = r_pc;

`ifdef URV_FETCH_ALIGN_CHECK_EN
  // The tag of the first fetch after an unaligned redirect carries the raw target.
  logic        r_mis_pend;
  logic [31:0] r_mis_pc;

  assign w_tag_din = {r_mis_pend, r_mis_pend ? r_mis_pc : r_pc};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mis_pend <= 1'b0;
      r_mis_pc   <= '0;
    end else if (x_bra_i) begin
      r_mis_pend <= |x_bra_target_i[1:0];
      r_mis_pc   <= x_bra_target_i;
    end else if (w_issue) begin
      r_mis_pend <= 1'b0;
    end
  end
`else
  assign w_tag_din = r_pc;
`endif

  urv_fetch_queue #(.WIDTH(c_tw), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (x_bra_i),
    .push_i  (w_issue),
    .pop_i   (w_accept),
    .data_i  (w_tag_din),
    .data_o  (w_tag_dout),
    .count_o (w_tag_count),
    .full_o  (w_tag_full),
    .empty_o (w_tag_empty)
  );

  urv_fetch_queue #(.WIDTH(c_qw), .DEPTH(MAX_OUTSTANDING)) u_queue (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (x_bra_i),
    .push_i  (w_accept),
    .pop_i   (w_q_pop),
    .data_i  ({w_tag_dout, im_data_i}),
    .data_o  (w_q_dout),
    .count_o (w_q_count),
    .full_o  (w_q_full),
    .empty_o (w_q_empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= FETCH_BOOT;
      r_pc    <= RESET_VECTOR;
      r_out   <= '0;
      r_drop  <= '0;
    end else begin
      r_out <= r_out + c_cw'(w_issue) - c_cw'(im_valid_i);
      if (x_bra_i) begin
        // Everything still in flight, minus a word landing now, must be discarded.
        r_pc    <= w_target;
        r_drop  <= w_drop_next;
        r_state <= (w_drop_next != '0) ? FETCH_FLUSH : FETCH_RUN;
      end else begin
        if (w_issue) r_pc <= r_pc + 32'd4;
        case (r_state)
          FETCH_BOOT: r_state <= FETCH_RUN;
          FETCH_FLUSH: begin
            if (im_valid_i) begin
              r_drop <= r_drop - c_cw'(1);
              if (r_drop == c_cw'(1)) r_state <= FETCH_RUN;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      f_valid_o      <= 1'b0;
      f_ir_o         <= c_nop;
      f_pc_o         <= '0;
`ifdef URV_FETCH_ALIGN_CHECK_EN
      f_misaligned_o <= 1'b0;
`endif
    end else if (x_bra_i || f_kill_i) begin
      f_valid_o <= 1'b0;
    end else if (!f_stall_i) begin
      f_valid_o <= !w_q_empty;
      if (!w_q_empty) begin
        f_ir_o         <= w_q_dout[31:0];
        f_pc_o         <= w_q_dout[63:32];
`ifdef URV_FETCH_ALIGN_CHECK_EN
        f_misaligned_o <= w_q_dout[64];
`endif
      end
    end
  end

`ifndef SYNTHESIS
  a_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(w_accept && w_q_full && !w_q_pop));
  a_resp_idle: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(im_valid_i && (r_out == '0)));
  a_tag_sane: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(w_issue && w_tag_full) && !(w_accept && w_tag_empty) && (w_tag_count <= r_out));
`endif

endmodule
`default_nettype wire

// File: tb/tb_urv_fetch.sv
`default_nettype none
// Bench for urv_fetch: queue-based reference model checked every cycle, plus
// literal delivery sequences per directed scenario.
module tb_urv_fetch;

`ifdef URV_FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_stall = 1'b0, f_kill = 1'b0, x_bra = 1'b0;
  logic [31:0] x_tgt = '0;
  logic        im_rd;
  logic [31:0] im_addr;
  logic [31:0] im_data = '0;
  logic        im_valid = 1'b0;
  logic [31:0] f_ir, f_pc;
  logic        f_valid, f_mis;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  urv_fetch dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .f_stall_i      (f_stall),
    .f_kill_i       (f_kill),
    .x_bra_i        (x_bra),
    .x_bra_target_i (x_tgt),
    .im_rd_o        (im_rd),
    .im_addr_o      (im_addr),
    .im_data_i      (im_data),
    .im_valid_i     (im_valid),
    .f_ir_o         (f_ir),
    .f_pc_o         (f_pc),
`ifdef URV_FETCH_ALIGN_CHECK_EN
    .f_misaligned_o (f_mis),
`endif
    .f_valid_o      (f_valid)
  );
`ifndef URV_FETCH_ALIGN_CHECK_EN
  assign f_mis = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory: in-order responses, programmable latency
  typedef struct {logic [31:0] addr; int due;} req_t;
  req_t mem_q[$];
  int   cyc = 0;
  int   lat = 1;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        mem_q.delete();
        im_valid = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        im_valid = 1'b1;
        im_data  = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        im_valid = 1'b0;
        im_data  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      if (rst_n && im_rd) mem_q.push_back('{im_addr, cyc + lat});
    end
  end

  // ---------------- reference model + per-cycle compare
  typedef struct {logic [31:0] pc; logic mis; logic doomed;} fl_t;
  fl_t         m_infl[$];
  fl_t         m_q[$];
  logic [31:0] m_pc, m_fpc, m_fir, m_pend_pc;
  logic        m_boot, m_fv, m_fmis, m_pend;
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_ir[$];
  logic        dlv_mis[$];

  always @(negedge clk) begin : compare
    fl_t  e;
    logic exp_issue;
    if (!rst_n) begin
      chk("rst_valid", f_valid, 32'd0);
      chk("rst_rd",    im_rd,   32'd0);
      chk("rst_addr",  im_addr, 32'h0);
      chk("rst_ir",    f_ir,    32'h0000_0013);
      chk("rst_pc",    f_pc,    32'h0);
      m_infl.delete(); m_q.delete();
      m_pc = 32'h0; m_boot = 1'b1; m_pend = 1'b0; m_pend_pc = '0;
      m_fv = 1'b0; m_fpc = '0; m_fir = 32'h0000_0013; m_fmis = 1'b0;
    end else begin
      chk("f_valid", f_valid, m_fv);
      chk("f_pc",    f_pc,    m_fpc);
      chk("f_ir",    f_ir,    m_fir);
      chk("f_mis",   f_mis,   m_fmis);
      exp_issue = !m_boot && (m_infl.size() + m_q.size() < 2) && !x_bra;
      chk("im_rd", im_rd, exp_issue);
      if (exp_issue) chk("im_addr", im_addr, m_pc);
      if (f_valid && !f_stall && !f_kill && !x_bra) begin
        dlv_pc.push_back(f_pc); dlv_ir.push_back(f_ir); dlv_mis.push_back(f_mis);
      end
      // state for the next cycle
      m_boot = 1'b0;
      if (x_bra || f_kill) m_fv = 1'b0;
      else if (!f_stall) begin
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_fv = 1'b1; m_fpc = e.pc; m_fmis = e.mis;
          m_fir = mem_word({e.pc[31:2], 2'b00});
        end else m_fv = 1'b0;
      end
      if (im_valid && m_infl.size() > 0) begin
        e = m_infl.pop_front();
        if (!e.doomed && !x_bra) m_q.push_back(e);
      end
      if (x_bra) begin
        m_q.delete();
        for (int i = 0; i < m_infl.size(); i++) m_infl[i].doomed = 1'b1;
        m_pc      = {x_tgt[31:2], 2'b00};
        m_pend    = ALIGN_EN && (x_tgt[1:0] != 2'b00);
        m_pend_pc = x_tgt;
      end else if (exp_issue) begin
        e.pc = m_pend ? m_pend_pc : m_pc; e.mis = m_pend; e.doomed = 1'b0;
        m_infl.push_back(e);
        m_pend = 1'b0;
        m_pc   = m_pc + 32'd4;
      end
    end
  end

  // ---------------- directed stimulus
  task automatic tick(); @(posedge clk); #2; endtask

  task automatic wait_dlv(input int n, input string name);
    int k = 0;
    while (dlv_pc.size() < n && k < 300) begin tick(); k++; end
    chk(name, dlv_pc.size() >= n, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] t);
    x_bra = 1'b1; x_tgt = t;
    tick();
    x_bra = 1'b0;
  endtask

  task automatic chk_seq(input string name, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) chk(name, dlv_pc[i], base + 32'(4 * i));
  endtask

  initial begin : stim
    logic [31:0] last;
    int          k;
    repeat (3) tick();
    chk("rst_lit_ir", f_ir, 32'h0000_0013);
    chk("rst_lit_valid", f_valid, 32'd0);
    dlv_pc.delete(); dlv_ir.delete(); dlv_mis.delete();
    rst_n = 1'b1;

    // streaming, latency 1
    wait_dlv(6, "s1_timeout");
    chk_seq("s1_pc", 32'h0, 6);
    chk("s1_ir0", dlv_ir[0], 32'h1357_6420);
    chk("s1_ir1", dlv_ir[1], 32'h1353_6424);

    // decode stall for 5 cycles
    last = dlv_pc[$];
    dlv_pc.delete();
    f_stall = 1'b1; repeat (5) tick(); f_stall = 1'b0;
    wait_dlv(6, "s2_timeout");
    chk_seq("s2_pc", last + 32'd4, 6);

    // redirect to 0x100 with two reads in flight (latency 3)
    lat = 3;
    k = 0;
    while (m_infl.size() != 2 && k < 30) begin tick(); k++; end
    chk("s3_two_outstanding", im_rd, 32'd0);
    dlv_pc.delete();
    redirect(32'h100);
    wait_dlv(3, "s3_timeout");
    chk_seq("s3_pc", 32'h100, 3);

    // redirect coinciding with a response and a stall
    lat = 2;
    k = 0;
    while (!im_valid && k < 30) begin tick(); k++; end
    chk("s4_resp_seen", im_valid, 32'd1);
    f_stall = 1'b1; x_bra = 1'b1; x_tgt = 32'h200;
    dlv_pc.delete();
    tick();
    x_bra = 1'b0;
    chk("s4_valid_cleared", f_valid, 32'd0);
    f_stall = 1'b0;
    wait_dlv(2, "s4_timeout");
    chk_seq("s4_pc", 32'h200, 2);

    // PC wrap
    lat = 1;
    dlv_pc.delete();
    redirect(32'hFFFF_FFF8);
    wait_dlv(4, "s5_timeout");
    chk_seq("s5_pc", 32'hFFFF_FFF8, 4);

    // kill leaves the queue intact
    repeat (3) tick();
    f_kill = 1'b1; tick(); f_kill = 1'b0;
    chk("s6_kill_valid", f_valid, 32'd0);
    dlv_pc.delete();
    wait_dlv(4, "s6_timeout");
    for (int i = 1; i < 4; i++) chk("s6_contig", dlv_pc[i], dlv_pc[i-1] + 32'd4);

    // unaligned redirect
    dlv_pc.delete(); dlv_mis.delete();
    redirect(32'h102);
    wait_dlv(2, "s7_timeout");
    chk("s7_pc0", dlv_pc[0], ALIGN_EN ? 32'h102 : 32'h100);
    chk("s7_pc1", dlv_pc[1], 32'h104);
    chk("s7_mis0", dlv_mis[0], ALIGN_EN);
    chk("s7_mis1", dlv_mis[1], 32'd0);

    // asynchronous reset mid-stream
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("s8_async_valid", f_valid, 32'd0);
    chk("s8_async_rd",    im_rd,   32'd0);
    chk("s8_async_pc",    f_pc,    32'h0);
    chk("s8_async_ir",    f_ir,    32'h0000_0013);
    repeat (2) tick();
    dlv_pc.delete();
    rst_n = 1'b1;
    wait_dlv(3, "s8_timeout");
    chk_seq("s8_pc", 32'h0, 3);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/urv_fetch.md
Name: urv_fetch

Overview:
- Instruction fetch stage of the uRV pipeline; sits directly upstream of decode and feeds it f_ir/f_pc/f_valid.
- Generates the sequential PC, issues in-order reads to instruction memory and buffers returned words in a 2-entry queue, so that decode stalls never lose data.
- Redirects on taken branch/jump/trap from the execute stage and discards every in-flight fetch.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first PC fetched after reset.
- MAX_OUTSTANDING, 2, maximum memory reads in flight; also the instruction queue depth.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- f_stall_i  in  1  decode not accepting; hold f_* outputs
- f_kill_i  in  1  invalidate f_valid_o next cycle (pipeline flush)
- x_bra_i  in  1  redirect request, one-cycle pulse
- x_bra_target_i  in  32  redirect PC
- im_rd_o  out  1  memory read strobe
- im_addr_o  out  32  read address, word aligned
- im_data_i  in  32  read data
- im_valid_i  in  1  read data valid; responses in order, latency >= 1
- f_ir_o  out  32  instruction to decode
- f_pc_o  out  32  PC of f_ir_o
- f_valid_o  out  1  f_ir_o/f_pc_o valid

Behaviour:
- Reset:
  - Asynchronous. pc <= RESET_VECTOR; queue empty; outstanding=0; drop=0.
  - im_rd_o=0, im_addr_o=RESET_VECTOR, f_valid_o=0, f_ir_o=32'h0000_0013 (NOP), f_pc_o=0.
  - State BOOT. A reset asserted mid-operation aborts everything immediately.
- States:
  - BOOT: one cycle after reset release, no request -> RUN.
  - RUN: normal fetch.
  - FLUSH: drop responses while drop!=0 -> RUN when drop reaches 0 (or same cycle if the last one arrives).
- Issue:
  - im_rd_o=1 when state RUN/FLUSH && outstanding + queue_count < MAX_OUTSTANDING && !x_bra_i.
  - On issue: im_addr_o=pc, pc <= pc+4 (32-bit wrap, FFFF_FFFC -> 0).
  - im_rd_o and im_addr_o are combinational from registered state.
  - The credit rule guarantees every response has a queue slot.
- Response:
  - im_valid_i with drop==0: push {pc_tag, im_data_i} into the queue.
  - PC tags come from a parallel tag FIFO written at issue.
  - im_valid_i with drop!=0: discard, drop <= drop-1.
- Output register:
  - When !f_stall_i: if the queue is non-empty, pop into f_ir_o/f_pc_o and set f_valid_o=1; else f_valid_o <= 0.
  - When f_stall_i: all f_* hold.
  - Latency: response at cycle N appears on f_* at N+1 with empty queue and no stall.
  - Queue bypass is not allowed; registered output only.
- Redirect (x_bra_i=1):
  - pc <= x_bra_target_i.
  - Queue and tag FIFO cleared.
  - drop <= outstanding minus any response arriving this cycle; that response is discarded.
  - f_valid_o <= 0 regardless of f_stall_i.
  - No issue this cycle. Next state FLUSH if the new drop!=0, else RUN.
  - Redirect during FLUSH accumulates drop.
- f_kill_i without x_bra_i: f_valid_o <= 0 only; queue untouched. Redirect has priority over kill.
- Simultaneous push and pop on a full queue is legal; count unchanged.
- Pop on empty is a no-op.
- Assertions (sim only): push when full, im_valid_i with outstanding==0.

Optional Feature:
- Macro URV_FETCH_ALIGN_CHECK_EN.
- When defined, adds output f_misaligned_o (1 bit, reset 0):
  - A redirect with x_bra_target_i[1:0]!=0 still loads pc with bits[1:0] forced to 0.
  - The first instruction delivered after it carries f_misaligned_o=1, with f_pc_o holding the original unaligned target.
  - f_misaligned_o clears on the next pop.
- When undefined: port absent; target bits[1:0] silently ignored (forced to 0).

Decomposition:
- Shared package/defines file (urv_defs): NOP encoding 32'h0000_0013, fetch state encodings (FETCH_BOOT, FETCH_RUN, FETCH_FLUSH), RESET_VECTOR default.
- One sub-module: urv_fetch_queue, a parameterised synchronous FIFO (width 64 = pc+ir, depth MAX_OUTSTANDING) with flush, count, full, empty.

Test Plan:
- Reset release, memory latency 1, no stall -> addresses 0,4,8,... issued from cycle 2; f_pc_o 0,4,8 on consecutive cycles with matching f_ir_o; f_valid_o continuous.
- f_stall_i high 5 cycles mid-stream -> f_* frozen; at most 2 outstanding plus queued; no instruction lost or duplicated after release.
- x_bra_i to 0x100 with 2 reads outstanding (latency 3) -> both responses discarded; next f_pc_o is 0x100; FLUSH lasts until drop=0.
- Redirect in the same cycle as im_valid_i and f_stall_i=1 -> arriving word dropped; f_valid_o=0 next cycle; first valid f_pc_o equals target.
- pc at 0xFFFF_FFF8, no redirect -> f_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- URV_FETCH_ALIGN_CHECK_EN defined, redirect to 0x102 -> im_addr_o 0x100; first delivered f_pc_o 0x102 with f_misaligned_o=1; next instruction f_misaligned_o=0.
